// File: rtl/alu.sv
// Nibble ALU: one registered 4-bit operation per accepted input, with a carry or
// shift-out bit so wider words can be processed as chained nibble operations.
module alu (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [2:0] cmd,
  input  logic       carry_in,
  input  logic       b_inv,
  input  logic       carry_disable,
  input  logic [3:0] d1,
  input  logic [3:0] d2,
  output logic       out_valid,
  output logic [3:0] res,
  output logic       carry_out,
  output logic       zero
);

  localparam logic [2:0] CMD_ADD   = 3'b000;
  localparam logic [2:0] CMD_RSHFT = 3'b001;
  localparam logic [2:0] CMD_AND   = 3'b010;
  localparam logic [2:0] CMD_OR    = 3'b011;
  localparam logic [2:0] CMD_XOR   = 3'b100;
  localparam logic [2:0] CMD_LSHFT = 3'b101;

  logic [3:0] b_s;
  logic       cin_s;
  logic [4:0] sum_s;
  logic [3:0] res_s;
  logic       cout_s;

  logic [3:0] res_r;
  logic       cout_r;
  logic       zero_r;
  logic       valid_r;

  // Operand preparation and adder; the carry mux keeps a don't-care carry_in out of the sum
  always_comb begin
    b_s   = b_inv ? ~d2 : d2;
    cin_s = carry_disable ? 1'b0 : carry_in;
    sum_s = {1'b0, d1} + {1'b0, b_s} + {4'b0000, cin_s};
  end

  // Result and carry/shift-out selection; shifts use raw d2 and never look at d1
  always_comb begin
    res_s  = 4'h0;
    cout_s = 1'b0;
    case (cmd)
      CMD_ADD: begin
        res_s  = sum_s[3:0];
        cout_s = carry_disable ? 1'b0 : sum_s[4];
      end
      CMD_RSHFT: begin
        res_s  = {carry_in, d2[3:1]};
        cout_s = d2[0];
      end
      CMD_AND: begin
        res_s  = d1 & b_s;
        cout_s = 1'b0;
      end
      CMD_OR: begin
        res_s  = d1 | b_s;
        cout_s = 1'b0;
      end
      CMD_XOR: begin
        res_s  = d1 ^ b_s;
        cout_s = 1'b0;
      end
      CMD_LSHFT: begin
        res_s  = {d2[2:0], carry_in};
        cout_s = d2[3];
      end
      default: begin
        res_s  = 4'h0;
        cout_s = 1'b0;
      end
    endcase
  end

  // Output registers: reset wins, otherwise load on in_valid and hold when idle
  always_ff @(posedge clk) begin
    if (rst) begin
      res_r   <= 4'h0;
      cout_r  <= 1'b0;
      zero_r  <= 1'b1;
      valid_r <= 1'b0;
    end else if (in_valid) begin
      res_r   <= res_s;
      cout_r  <= cout_s;
      zero_r  <= (res_s == 4'h0);
      valid_r <= 1'b1;
    end else begin
      valid_r <= 1'b0;
    end
  end

  assign res       = res_r;
  assign carry_out = cout_r;
  assign zero      = zero_r;
  assign out_valid = valid_r;

endmodule

// File: tb/tb_alu.sv
// Scoreboard bench for the nibble ALU: the driver pushes one expectation per cycle,
// the monitor pops and compares one cycle later.
module tb_alu;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_valid = 1'b0;
  logic [2:0] cmd = 3'b000;
  logic       carry_in = 1'b0;
  logic       b_inv = 1'b0;
  logic       carry_disable = 1'b0;
  logic [3:0] d1 = 4'h0;
  logic [3:0] d2 = 4'h0;
  logic       out_valid;
  logic [3:0] res;
  logic       carry_out;
  logic       zero;

  int total = 0;
  int bad = 0;

  localparam int K_VALID = 0;
  localparam int K_HOLD  = 1;
  localparam int K_RESET = 2;

  typedef struct {
    int         kind;
    logic [3:0] r;
    logic       co;
    string      name;
  } exp_t;

  exp_t sb[$];

  alu dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .cmd(cmd), .carry_in(carry_in),
    .b_inv(b_inv), .carry_disable(carry_disable), .d1(d1), .d2(d2),
    .out_valid(out_valid), .res(res), .carry_out(carry_out), .zero(zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, want);
    end
  endtask

  // Reference behaviour written from the operation rules using plain integer arithmetic
  function automatic void model(input int c, input int ci, input int bi, input int cd,
                                input int a, input int d, output logic [3:0] r, output logic co);
    int b, s, rv, cv;
    b = bi ? 15 - d : d;
    rv = 0;
    cv = 0;
    case (c)
      0: begin s = a + b + (cd ? 0 : ci); rv = s % 16; cv = cd ? 0 : s / 16; end
      1: begin rv = ci * 8 + d / 2; cv = d % 2; end
      2: rv = a & b;
      3: rv = a | b;
      4: rv = a ^ b;
      5: begin rv = (d * 2 + ci) % 16; cv = d / 8; end
      default: begin rv = 0; cv = 0; end
    endcase
    r = 4'(rv);
    co = (cv != 0);
  endfunction

  task automatic send(input logic [2:0] c, input logic ci, input logic bi, input logic cd,
                      input logic [3:0] a, input logic [3:0] d);
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b1; cmd = c; carry_in = ci; b_inv = bi;
    carry_disable = cd; d1 = a; d2 = d;
  endtask

  task automatic push_exp(input string nm, input logic [3:0] r, input logic co);
    exp_t e;
    e.kind = K_VALID; e.r = r; e.co = co; e.name = nm;
    sb.push_back(e);
  endtask

  task automatic op_rand(input string nm, input logic [2:0] c, input logic ci, input logic bi,
                         input logic cd, input logic [3:0] a, input logic [3:0] d);
    logic [3:0] r;
    logic co;
    send(c, ci, bi, cd, a, d);
    model(int'(c), int'(ci), int'(bi), int'(cd), int'(a), int'(d), r, co);
    push_exp(nm, r, co);
  endtask

  task automatic idle();
    exp_t e;
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    d1 = 4'($urandom); d2 = 4'($urandom); cmd = 3'($urandom);
    e.kind = K_HOLD; e.r = 4'h0; e.co = 1'b0; e.name = "hold";
    sb.push_back(e);
  endtask

  task automatic do_reset();
    exp_t e;
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b1; cmd = 3'b000; d1 = 4'hF; d2 = 4'hF; carry_in = 1'b1;
    e.kind = K_RESET; e.r = 4'h0; e.co = 1'b0; e.name = "reset";
    sb.push_back(e);
  endtask

  // Monitor: one expectation per clock, tracking held output values across idle cycles
  initial begin
    exp_t e;
    logic [3:0] held_r = 4'h0;
    logic held_co = 1'b0;
    logic held_z = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() != 0) begin
        e = sb.pop_front();
        case (e.kind)
          K_RESET: begin
            chk("rst_valid", {7'b0, out_valid}, 8'h00);
            chk("rst_res", {4'h0, res}, 8'h00);
            chk("rst_cz", {6'b0, carry_out, zero}, 8'h01);
            held_r = 4'h0; held_co = 1'b0; held_z = 1'b1;
          end
          K_HOLD: begin
            chk("hold_valid", {7'b0, out_valid}, 8'h00);
            chk("hold_out", {2'b0, carry_out, zero, res}, {2'b0, held_co, held_z, held_r});
          end
          default: begin
            chk({e.name, "_valid"}, {7'b0, out_valid}, 8'h01);
            chk({e.name, "_out"}, {2'b0, carry_out, zero, res},
                {2'b0, e.co, (e.r == 4'h0), e.r});
            held_r = e.r; held_co = e.co; held_z = (e.r == 4'h0);
          end
        endcase
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "timeout");
  end

  // Driver: directed cases from the operation rules, word-level chains, then random traffic
  initial begin
    logic [31:0] wa, wb, wr, wbx;
    logic [63:0] part, m;
    logic ci, c0;
    logic [3:0] r;
    logic co;

    do_reset();
    do_reset();

    send(3'b000, 1'b0, 1'b0, 1'b0, 4'hF, 4'h1); push_exp("add_f1", 4'h0, 1'b1);
    send(3'b000, 1'b1, 1'b0, 1'b0, 4'hE, 4'h0); push_exp("add_e0", 4'hF, 1'b0);
    send(3'b000, 1'b1, 1'b1, 1'b0, 4'h2, 4'h3); push_exp("sub_23", 4'hF, 1'b0);
    send(3'b000, 1'b1, 1'b1, 1'b0, 4'h5, 4'h3); push_exp("sub_53", 4'h2, 1'b1);
    send(3'b000, 1'b1, 1'b0, 1'b1, 4'hF, 4'hF); push_exp("add_cd", 4'hE, 1'b0);
    send(3'b001, 1'b1, 1'b0, 1'b0, 4'hx, 4'h1); push_exp("rsh_1", 4'h8, 1'b1);
    send(3'b101, 1'b0, 1'b0, 1'b0, 4'hx, 4'h9); push_exp("lsh_9", 4'h2, 1'b1);
    send(3'b010, 1'b0, 1'b0, 1'b0, 4'hC, 4'hA); push_exp("and_ca", 4'h8, 1'b0);
    send(3'b011, 1'b0, 1'b0, 1'b0, 4'hC, 4'hA); push_exp("or_ca", 4'hE, 1'b0);
    send(3'b100, 1'b0, 1'b0, 1'b0, 4'hC, 4'hA); push_exp("xor_ca", 4'h6, 1'b0);
    send(3'b010, 1'b0, 1'b1, 1'b0, 4'hC, 4'hA); push_exp("andn_ca", 4'h4, 1'b0);
    send(3'b110, 1'b1, 1'b1, 1'b0, 4'hF, 4'hF); push_exp("rsv_6", 4'h0, 1'b0);
    send(3'b111, 1'b1, 1'b0, 1'b0, 4'hF, 4'hF); push_exp("rsv_7", 4'h0, 1'b0);
    send(3'b011, 1'b0, 1'b0, 1'b0, 4'h5, 4'h3); push_exp("or_53", 4'h7, 1'b0);
    idle(); idle(); idle();
    do_reset();
    idle();

    // Right-shift words MSB to LSB; expectations come from shifting the whole word
    for (int t = 0; t < 4; t++) begin
      wa = (t == 0) ? 32'h0600_0000 : $urandom;
      wr = wa >> 1;
      ci = 1'b0;
      for (int k = 7; k >= 0; k--) begin
        send(3'b001, ci, 1'($urandom), 1'b0, 4'($urandom), wa[4*k +: 4]);
        push_exp("rsh_word", wr[4*k +: 4], wa[4*k]);
        ci = wa[4*k];
      end
    end

    // Add and subtract words LSB to MSB; carries come from partial 64-bit sums
    for (int t = 0; t < 6; t++) begin
      wa = $urandom;
      wb = $urandom;
      c0 = t[0];
      wbx = c0 ? ~wb : wb;
      ci = c0;
      wr = wa + wbx + {31'b0, c0};
      for (int k = 0; k < 8; k++) begin
        m = (64'd1 << (4 * (k + 1))) - 64'd1;
        part = ({32'b0, wa} & m) + ({32'b0, wbx} & m) + {63'b0, c0};
        send(3'b000, ci, c0, 1'b0, wa[4*k +: 4], wb[4*k +: 4]);
        push_exp(c0 ? "sub_word" : "add_word", wr[4*k +: 4], part[4*(k+1)]);
        ci = part[4*(k+1)];
      end
    end

    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 19))
        0: do_reset();
        1, 2: idle();
        default: op_rand("rand", 3'($urandom), 1'($urandom), 1'($urandom),
                         1'($urandom_range(0, 3) == 0), 4'($urandom), 4'($urandom));
      endcase
    end
    idle();

    repeat (3) @(negedge clk);
    chk("sb_drained", 8'(sb.size()), 8'h00);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
